// File: rtl/timer_pkg.sv
// timer_pkg: shared address map, register bit positions and handshake FSM states
package timer_pkg;
  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TIER = 8'h03;
  localparam int TCR_LOAD = 7;
  localparam int TCR_DOWN = 5;
  localparam int TCR_EN   = 4;
  localparam int TCR_CLK  = 0;
  localparam logic [7:0] TCR_MASK  = 8'h33;
  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;
  localparam logic [7:0] TSR_MASK  = 8'h03;
  localparam logic [7:0] TIER_MASK = 8'h03;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/timer_apb_regs_fsm.sv
// apb_slave_fsm: APB access handshake with wait states, yields one-cycle pready and read/write strobes
module apb_slave_fsm
  import timer_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic wr_en,
  output logic rd_en,
  output logic pready
);
  state_e     state_q;
  logic [1:0] cnt_q;
  logic       pready_q, wr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      pready_q <= 1'b0;
      case (state_q)
        IDLE: if (psel && penable) begin
          if (WAIT_STATES == 0) begin
            state_q  <= RESP;
            pready_q <= 1'b1;
            wr_q     <= pwrite;
          end else begin
            state_q <= WAIT;
            cnt_q   <= 2'(WAIT_STATES - 1);
          end
        end
        WAIT: if (!(psel && penable)) state_q <= IDLE;
          else if (cnt_q == 2'd0) begin
            state_q  <= RESP;
            pready_q <= 1'b1;
            wr_q     <= pwrite;
          end else cnt_q <= cnt_q - 2'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign pready = pready_q;
  assign wr_en  = pready_q & wr_q;
  assign rd_en  = pready_q & ~wr_q;
endmodule

// File: rtl/timer_apb_regs.sv
// timer_apb_regs: APB register block for the 8-bit timer (TDR, TCR, W1C TSR, TIER, irq)
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              ovf_evt,
  input  logic              udf_evt,
  output logic [7:0]        tdr_val,
  output logic              load_pulse,
  output logic              cnt_en,
  output logic              cnt_down,
  output logic [1:0]        clk_sel,
  output logic              irq
);
  logic              wr_en, rd_en, err;
  logic              is_tdr, is_tcr, is_tsr, is_tier;
  logic [DATA_W-1:0] tdr_q, tcr_q, tsr_q, tier_q;
  logic [DATA_W-1:0] tdr_d, tcr_d, tsr_d, tier_d, tsr_set;
  logic              load_q, irq_q;
  apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .wr_en(wr_en), .rd_en(rd_en), .pready(pready)
  );
  assign is_tdr  = paddr == ADDR_W'(ADDR_TDR);
  assign is_tcr  = paddr == ADDR_W'(ADDR_TCR);
  assign is_tsr  = paddr == ADDR_W'(ADDR_TSR);
  assign is_tier = paddr == ADDR_W'(ADDR_TIER);
  assign err     = paddr > ADDR_W'(ADDR_TIER);
  always_comb begin
    tsr_set          = '0;
    tsr_set[TSR_OVF] = ovf_evt;
    tsr_set[TSR_UDF] = udf_evt;
    tdr_d  = wr_en && is_tdr ? pwdata : tdr_q;
    tcr_d  = wr_en && is_tcr ? pwdata & DATA_W'(TCR_MASK) : tcr_q;
    tier_d = wr_en && is_tier ? pwdata & DATA_W'(TIER_MASK) : tier_q;
    tsr_d  = (tsr_q & ~(wr_en && is_tsr ? pwdata & DATA_W'(TSR_MASK) : '0)) | tsr_set;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tdr_q  <= '0;
      tcr_q  <= '0;
      tsr_q  <= '0;
      tier_q <= '0;
      load_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      tdr_q  <= tdr_d;
      tcr_q  <= tcr_d;
      tsr_q  <= tsr_d;
      tier_q <= tier_d;
      load_q <= wr_en && is_tcr && pwdata[TCR_LOAD];
      irq_q  <= |(tsr_q & tier_q);
    end
  end
  assign prdata     = !rd_en ? '0 : is_tdr ? tdr_q : is_tcr ? tcr_q : is_tsr ? tsr_q : is_tier ? tier_q : '0;
  assign pslverr    = pready & err;
  assign tdr_val    = tdr_q[7:0];
  assign load_pulse = load_q;
  assign cnt_en     = tcr_q[TCR_EN];
  assign cnt_down   = tcr_q[TCR_DOWN];
  assign clk_sel    = tcr_q[TCR_CLK +: 2];
  assign irq        = irq_q;
endmodule

// File: tb/tb_timer_apb_regs.sv
// tb_timer_apb_regs: directed scoreboard bench for timer_apb_regs
module tb_timer_apb_regs;
  logic       clk = 1'b0;
  logic       rst, psel, penable, pwrite, ovf_evt, udf_evt;
  logic [7:0] paddr, pwdata, prdata, tdr_val;
  logic       pready, pslverr, load_pulse, cnt_en, cnt_down, irq;
  logic [1:0] clk_sel;
  typedef struct {
    logic [7:0] d;
    logic       e;
    string      tag;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  timer_apb_regs dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .ovf_evt(ovf_evt), .udf_evt(udf_evt), .tdr_val(tdr_val), .load_pulse(load_pulse),
    .cnt_en(cnt_en), .cnt_down(cnt_down), .clk_sel(clk_sel), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp, input logic experr, input logic coll);
    exp_t e;
    int   lat;
    sb.push_back('{exp, experr, tag});
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!pready && lat < 8);
    chk({tag, "_latency"}, lat, 2);
    e = sb.pop_front();
    chk({e.tag, "_prdata"}, prdata, e.d);
    chk({e.tag, "_pslverr"}, pslverr, e.e);
    if (coll) ovf_evt = 1'b1;
    psel = 1'b0; penable = 1'b0;
    if (coll) begin
      @(negedge clk);
      ovf_evt = 1'b0;
    end
  endtask
  task automatic pulse(input logic o, input logic u);
    @(negedge clk);
    ovf_evt = o; udf_evt = u;
    @(negedge clk);
    ovf_evt = 1'b0; udf_evt = 1'b0;
  endtask
  initial begin
    logic [7:0] r;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    ovf_evt = 1'b0; udf_evt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pready", pready, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_irq", irq, 0);
    chk("rst_load", load_pulse, 0);
    chk("rst_tdr", tdr_val, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) xfer($sformatf("rst_rd%0d", i), 1'b0, 8'(i), 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      r = 8'($urandom_range(0, 255));
      xfer("w1c_wr", 1'b1, 8'h02, r, 8'h00, 1'b0, 1'b0);
      xfer("w1c_rd", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    xfer("tsr_both", 1'b0, 8'h02, 8'h00, 8'h03, 1'b0, 1'b0);
    xfer("tsr_clr0_wr", 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
    xfer("tsr_clr0_rd", 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0);
    xfer("tsr_clr1_wr", 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0);
    xfer("tsr_clr1_rd", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    xfer("tier_wr", 1'b1, 8'h03, 8'hFD, 8'h00, 1'b0, 1'b0);
    xfer("tier_rd", 1'b0, 8'h03, 8'h00, 8'h01, 1'b0, 1'b0);
    chk("irq_idle", irq, 0);
    @(negedge clk);
    ovf_evt = 1'b1;
    @(negedge clk);
    ovf_evt = 1'b0;
    chk("irq_reg_delay", irq, 0);
    @(negedge clk);
    chk("irq_set", irq, 1);
    xfer("coll_wr", 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b1);
    xfer("coll_rd", 1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0);
    chk("coll_irq", irq, 1);
    xfer("clr_wr", 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
    xfer("clr_rd", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("irq_clr", irq, 0);
    xfer("tcr_wr", 1'b1, 8'h01, 8'hB3, 8'h00, 1'b0, 1'b0);
    chk("load_resp", load_pulse, 0);
    @(negedge clk);
    chk("load_hi", load_pulse, 1);
    chk("cnt_en", cnt_en, 1);
    chk("cnt_down", cnt_down, 1);
    chk("clk_sel", clk_sel, 2'b11);
    @(negedge clk);
    chk("load_lo", load_pulse, 0);
    xfer("tcr_rd", 1'b0, 8'h01, 8'h00, 8'h33, 1'b0, 1'b0);
    xfer("tdr_wr", 1'b1, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("tdr_val", tdr_val, 8'hA5);
    xfer("tdr_rd", 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0);
    xfer("err_rd", 1'b0, 8'h07, 8'h00, 8'h00, 1'b1, 1'b0);
    xfer("err_wr", 1'b1, 8'h07, 8'h5A, 8'h00, 1'b1, 1'b0);
    xfer("err_tdr_rd", 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_pready", pready, 0);
    end
    chk("abort_tdr", tdr_val, 8'hA5);
    xfer("abort_rd", 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0);
    pulse(1'b1, 1'b1);
    @(negedge clk);
    chk("pre_rst_irq", irq, 1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h03;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("mid_rst_pready", pready, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_pready", pready, 0);
    end
    chk("post_rst_tdr", tdr_val, 0);
    chk("post_rst_en", cnt_en, 0);
    chk("post_rst_clk", clk_sel, 0);
    chk("post_rst_irq", irq, 0);
    for (int i = 0; i < 4; i++) xfer($sformatf("post_rst_rd%0d", i), 1'b0, 8'(i), 8'h00, 8'h00, 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
